mem_map_ctrl: RTL and testbench

//  Parametrised memory-map controller between CPU data port and N RAM regions (program, sprite, tile, palette...).

---
 rtl/mem_map_ctrl_if.sv | 17 +
 rtl/mem_map_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_map_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_map_ctrl_if.sv
// CPU data-port bus between the CPU and the memory-map controller.
// The req/ack handshake plus read data and the bus-error flag.
interface mem_map_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              bus_err;

    modport master (output req, we, addr, wdata, input ack, rdata, bus_err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, bus_err);
endinterface

// File: rtl/mem_map_ctrl.sv
// Memory-map controller: decodes CPU accesses to RAM regions or the MMIO
// register file (status, sticky blank flags, IRQ mask, control registers).
module mem_map_ctrl #(
    parameter int                              ADDR_W      = 16,
    parameter int                              DATA_W      = 16,
    parameter int                              NUM_REGIONS = 4,
    parameter logic [ADDR_W*NUM_REGIONS-1:0]   REGION_BASE = {16'h4400, 16'h2400, 16'h2000, 16'h0000},
    parameter logic [8*NUM_REGIONS-1:0]        REGION_LOG2 = {8'd10, 8'd13, 8'd10, 8'd13},
    parameter logic [ADDR_W-1:0]               MMIO_BASE   = 16'h4800,
    parameter int                              NUM_MMIO    = 8,
    parameter int                              RD_LATENCY  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    mem_map_ctrl_if.slave                     bus,
    output logic [NUM_REGIONS-1:0]            o_region_en,
    output logic                              o_region_we,
    output logic [ADDR_W-1:0]                 o_region_addr,
    output logic [DATA_W-1:0]                 o_region_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0]     i_region_rdata,
    input  logic                              i_hbright,
    input  logic                              i_vbright,
    output logic [(NUM_MMIO-2)*DATA_W-1:0]    o_mmio_out,
    output logic                              o_irq
);
    localparam int                CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_W:0]   SIZE_ONE = 1;
    localparam logic [ADDR_W-1:0] MMIO_N   = ADDR_W'(NUM_MMIO);

    typedef enum logic [1:0] {S_IDLE, S_REGION, S_DONE} state_t;
    state_t r_state, w_next;

    logic [NUM_REGIONS-1:0] w_region_hit, r_sel;
    logic [ADDR_W-1:0]      w_region_off, w_off, w_mmio_off;
    logic                   w_found, w_mmio_hit, w_unmapped;
    logic [DATA_W-1:0]      w_mmio_rd, w_ram_rd, r_rdata;
    logic                   w_accept, w_cnt_last, w_done, w_mmio_wr;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_unmapped;
    logic                   r_hb_q, r_vb_q, r_hsticky, r_vsticky;
    logic [1:0]             r_mask;
    logic [DATA_W-1:0]      r_ctrl [2:NUM_MMIO-1];

    // Region decode: wrap-around subtraction makes the range check a single compare.
    always_comb begin
        w_region_hit = '0;
        w_region_off = '0;
        w_found      = 1'b0;
        w_off        = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            w_off = bus.addr - REGION_BASE[i*ADDR_W +: ADDR_W];
            if (!w_found && ({1'b0, w_off} < (SIZE_ONE << REGION_LOG2[i*8 +: 8]))) begin
                w_region_hit[i] = 1'b1;
                w_region_off    = w_off;
                w_found         = 1'b1;
            end
        end
    end

    assign w_mmio_off = bus.addr - MMIO_BASE;
    assign w_mmio_hit = !w_found && (w_mmio_off < MMIO_N);
    assign w_unmapped = !w_found && !w_mmio_hit;

    always_comb begin
        w_mmio_rd = '0;
        if (w_mmio_hit) begin
            if (w_mmio_off == '0)
                w_mmio_rd = DATA_W'({r_vsticky, r_hsticky, i_vbright, i_hbright});
            else if (w_mmio_off == ADDR_W'(1))
                w_mmio_rd = DATA_W'(r_mask);
            else
                for (int k = 2; k < NUM_MMIO; k++)
                    if (w_mmio_off == ADDR_W'(k)) w_mmio_rd = r_ctrl[k];
        end
    end

    always_comb begin
        w_ram_rd = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            if (r_sel[i]) w_ram_rd = w_ram_rd | i_region_rdata[i*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_cnt_last = (r_cnt == CNT_W'(RD_LATENCY - 1));
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.req;
                if (bus.req) w_next = w_found ? S_REGION : S_DONE;
            end
            S_REGION: if (w_cnt_last) w_next = S_DONE;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            o_region_en    <= '0;
            o_region_we    <= 1'b0;
            o_region_addr  <= '0;
            o_region_wdata <= '0;
            r_sel          <= '0;
            r_unmapped     <= 1'b0;
            r_rdata        <= '0;
            r_cnt          <= '0;
        end else begin
            o_region_en <= '0;
            o_region_we <= 1'b0;
            if (w_accept) begin
                o_region_en    <= w_region_hit;
                o_region_we    <= bus.we & w_found;
                o_region_addr  <= w_region_off;
                o_region_wdata <= bus.wdata;
                r_sel          <= w_region_hit;
                r_unmapped     <= w_unmapped;
                r_rdata        <= w_mmio_rd;
                r_cnt          <= '0;
            end else if (r_state == S_REGION) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_cnt_last) r_rdata <= w_ram_rd;
            end
        end
    end

    // MMIO writes land on the accept edge, after the read value was sampled.
    assign w_mmio_wr = w_accept && bus.we && w_mmio_hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hb_q    <= 1'b1;
            r_vb_q    <= 1'b1;
            r_hsticky <= 1'b0;
            r_vsticky <= 1'b0;
            r_mask    <= '0;
            for (int k = 2; k < NUM_MMIO; k++) r_ctrl[k] <= '0;
        end else begin
            r_hb_q    <= i_hbright;
            r_vb_q    <= i_vbright;
            r_hsticky <= (r_hb_q & ~i_hbright) |
                         (r_hsticky & ~(w_mmio_wr && w_mmio_off == '0 && bus.wdata[2]));
            r_vsticky <= (r_vb_q & ~i_vbright) |
                         (r_vsticky & ~(w_mmio_wr && w_mmio_off == '0 && bus.wdata[3]));
            if (w_mmio_wr && w_mmio_off == ADDR_W'(1)) r_mask <= bus.wdata[1:0];
            for (int k = 2; k < NUM_MMIO; k++)
                if (w_mmio_wr && w_mmio_off == ADDR_W'(k)) r_ctrl[k] <= bus.wdata;
        end
    end

    for (genvar g = 2; g < NUM_MMIO; g++) begin : g_mmio_out
        assign o_mmio_out[(g-2)*DATA_W +: DATA_W] = r_ctrl[g];
    end

    assign bus.ack     = w_done;
    assign bus.rdata   = w_done ? r_rdata : '0;
    assign bus.bus_err = w_done & r_unmapped;
    assign o_irq       = |({r_vsticky, r_hsticky} & r_mask);
endmodule

// File: tb/tb_mem_map_ctrl.sv
// Directed bench for mem_map_ctrl: vector table of single accesses plus
// hand sequences for sticky flags, reset abort and long read latency.
module tb_mem_map_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic hbright, vbright;
    always #5 clk = ~clk;

    localparam logic [63:0] RAM = {16'hA003, 16'hA002, 16'hBEEF, 16'hA000};

    mem_map_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();
    mem_map_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus3 ();

    logic [3:0]  en1, en3;
    logic        rwe1, rwe3, irq1, irq3;
    logic [15:0] raddr1, raddr3, rwdata1, rwdata3;
    logic [95:0] mmio1, mmio3;

    mem_map_ctrl #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .o_region_en(en1), .o_region_we(rwe1), .o_region_addr(raddr1),
        .o_region_wdata(rwdata1), .i_region_rdata(RAM),
        .i_hbright(hbright), .i_vbright(vbright),
        .o_mmio_out(mmio1), .o_irq(irq1)
    );

    mem_map_ctrl #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3),
        .o_region_en(en3), .o_region_we(rwe3), .o_region_addr(raddr3),
        .o_region_wdata(rwdata3), .i_region_rdata(RAM),
        .i_hbright(hbright), .i_vbright(vbright),
        .o_mmio_out(mmio3), .o_irq(irq3)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic        err;
        logic        chk_rd;
        logic [15:0] rd;
        logic [3:0]  en;
        logic [15:0] raddr;
    } vec_t;

    vec_t vecs[18];
    int   n_tests = 0;
    int   n_fail  = 0;

    int          a_lat, a_encnt;
    logic [15:0] a_rd, a_raddr, a_rwdata;
    logic        a_err, a_rwe;
    logic [3:0]  a_en;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic drop_v);
        @(negedge clk);
        bus1.req = 1'b1; bus1.we = we; bus1.addr = addr; bus1.wdata = wdata;
        if (drop_v) vbright = 1'b0;
        a_lat = -1; a_encnt = 0; a_en = '0; a_rd = '0; a_err = 1'b0;
        a_raddr = '0; a_rwe = 1'b0; a_rwdata = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (en1 != 4'b0) begin
                a_en = a_en | en1; a_encnt++;
                a_raddr = raddr1; a_rwe = rwe1; a_rwdata = rwdata1;
            end
            if (bus1.ack) begin
                a_lat = c; a_rd = bus1.rdata; a_err = bus1.bus_err;
                break;
            end
        end
        bus1.req = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 16'h2005, 16'h0000, 2, 1'b0, 1'b1, 16'hBEEF, 4'b0010, 16'h0005};
        vecs[1]  = '{1'b1, 16'h4803, 16'h1234, 1, 1'b0, 1'b0, 16'h0000, 4'b0000, 16'h0000};
        vecs[2]  = '{1'b0, 16'h4803, 16'h0000, 1, 1'b0, 1'b1, 16'h1234, 4'b0000, 16'h0000};
        vecs[3]  = '{1'b0, 16'hFFF0, 16'h0000, 1, 1'b1, 1'b1, 16'h0000, 4'b0000, 16'h0000};
        vecs[4]  = '{1'b0, 16'h0010, 16'h0000, 2, 1'b0, 1'b1, 16'hA000, 4'b0001, 16'h0010};
        vecs[5]  = '{1'b0, 16'h47FF, 16'h0000, 2, 1'b0, 1'b1, 16'hA003, 4'b1000, 16'h03FF};
        vecs[6]  = '{1'b0, 16'h2400, 16'h0000, 2, 1'b0, 1'b1, 16'hA002, 4'b0100, 16'h0000};
        vecs[7]  = '{1'b0, 16'h23FF, 16'h0000, 2, 1'b0, 1'b1, 16'hBEEF, 4'b0010, 16'h03FF};
        vecs[8]  = '{1'b0, 16'h4808, 16'h0000, 1, 1'b1, 1'b1, 16'h0000, 4'b0000, 16'h0000};
        vecs[9]  = '{1'b1, 16'h0123, 16'h5A5A, 2, 1'b0, 1'b0, 16'h0000, 4'b0001, 16'h0123};
        vecs[10] = '{1'b1, 16'h4807, 16'hC0DE, 1, 1'b0, 1'b0, 16'h0000, 4'b0000, 16'h0000};
        vecs[11] = '{1'b0, 16'h4807, 16'h0000, 1, 1'b0, 1'b1, 16'hC0DE, 4'b0000, 16'h0000};
        vecs[12] = '{1'b0, 16'h4800, 16'h0000, 1, 1'b0, 1'b1, 16'h0003, 4'b0000, 16'h0000};
        vecs[13] = '{1'b1, 16'h4801, 16'hFFFF, 1, 1'b0, 1'b0, 16'h0000, 4'b0000, 16'h0000};
        vecs[14] = '{1'b0, 16'h4801, 16'h0000, 1, 1'b0, 1'b1, 16'h0003, 4'b0000, 16'h0000};
        vecs[15] = '{1'b1, 16'h4802, 16'h0042, 1, 1'b0, 1'b0, 16'h0000, 4'b0000, 16'h0000};
        vecs[16] = '{1'b0, 16'h1FFF, 16'h0000, 2, 1'b0, 1'b1, 16'hA000, 4'b0001, 16'h1FFF};
        vecs[17] = '{1'b0, 16'h4400, 16'h0000, 2, 1'b0, 1'b1, 16'hA003, 4'b1000, 16'h0000};

        rst = 1'b0; hbright = 1'b1; vbright = 1'b1;
        bus1.req = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
        bus3.req = 1'b0; bus3.we = 1'b0; bus3.addr = '0; bus3.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ack", bus1.ack, 0);
        chk("reset rdata", bus1.rdata, 0);
        chk("reset bus_err", bus1.bus_err, 0);
        chk("reset region_en", {en1, en3}, 0);
        chk("reset region_we", rwe1, 0);
        chk("reset region_addr", raddr1, 0);
        chk("reset mmio_out", mmio1, 0);
        chk("reset irq", {irq1, irq3}, 0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0);
            chk($sformatf("v%0d latency", i), a_lat, vecs[i].lat);
            chk($sformatf("v%0d bus_err", i), a_err, vecs[i].err);
            if (vecs[i].chk_rd) chk($sformatf("v%0d rdata", i), a_rd, vecs[i].rd);
            chk($sformatf("v%0d region_en", i), a_en, vecs[i].en);
            chk($sformatf("v%0d en cycles", i), a_encnt, (vecs[i].en != 4'b0) ? 1 : 0);
            if (vecs[i].en != 4'b0) begin
                chk($sformatf("v%0d region_addr", i), a_raddr, vecs[i].raddr);
                chk($sformatf("v%0d region_we", i), a_rwe, vecs[i].we);
                if (vecs[i].we) chk($sformatf("v%0d region_wdata", i), a_rwdata, vecs[i].wdata);
            end
        end
        chk("mmio_out regs", mmio1, {16'hC0DE, 16'h0, 16'h0, 16'h0, 16'h1234, 16'h0042});
        chk("irq no sticky", irq1, 0);

        // Sticky vertical flag, W1C and set-wins-over-clear.
        do_access(1'b1, 16'h4801, 16'h0002, 1'b0);
        @(negedge clk) vbright = 1'b0;
        @(posedge clk); #1;
        chk("irq after vfall", irq1, 1);
        do_access(1'b0, 16'h4800, 16'h0, 1'b0);
        chk("status vsticky", a_rd, 16'h0009);
        @(negedge clk) vbright = 1'b1;
        do_access(1'b1, 16'h4800, 16'h0008, 1'b0);
        chk("irq after clear", irq1, 0);
        do_access(1'b0, 16'h4800, 16'h0, 1'b0);
        chk("status cleared", a_rd, 16'h0003);
        do_access(1'b1, 16'h4800, 16'h0008, 1'b1);
        chk("irq set wins", irq1, 1);
        do_access(1'b0, 16'h4800, 16'h0, 1'b0);
        chk("status set wins", a_rd, 16'h0009);
        @(negedge clk) vbright = 1'b1;
        do_access(1'b1, 16'h4800, 16'h0008, 1'b0);
        @(negedge clk) hbright = 1'b0;
        repeat (2) @(posedge clk);
        do_access(1'b0, 16'h4800, 16'h0, 1'b0);
        chk("status hsticky", a_rd, 16'h0006);
        chk("irq h masked", irq1, 0);
        @(negedge clk) hbright = 1'b1;

        // Reset during an in-flight region read.
        @(negedge clk);
        bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 16'h2005;
        @(posedge clk); #1;
        chk("abort en seen", en1, 4'b0010);
        @(negedge clk);
        rst = 1'b0; bus1.req = 1'b0;
        @(posedge clk); #1;
        chk("abort ack", bus1.ack, 0);
        chk("abort rdata", bus1.rdata, 0);
        chk("abort outputs", {en1, rwe1, raddr1, rwdata1, irq1}, 0);
        chk("abort mmio_out", mmio1, 0);
        @(negedge clk) rst = 1'b1;
        begin
            int acks = 0;
            repeat (5) begin
                @(posedge clk); #1;
                if (bus1.ack) acks++;
            end
            chk("abort no ack", acks, 0);
        end
        do_access(1'b0, 16'h2005, 16'h0, 1'b0);
        chk("post-abort latency", a_lat, 2);
        chk("post-abort rdata", a_rd, 16'hBEEF);

        // Long latency with req held across two transactions.
        begin
            int first = -1, second = -1, pulses = 0;
            @(negedge clk);
            bus3.req = 1'b1; bus3.we = 1'b0; bus3.addr = 16'h2005;
            for (int c = 1; c <= 30 && second < 0; c++) begin
                @(posedge clk); #1;
                if (en3 != 4'b0) pulses++;
                if (bus3.ack) begin
                    chk($sformatf("lat3 rdata c%0d", c), bus3.rdata, 16'hBEEF);
                    if (first < 0) first = c;
                    else second = c;
                end
            end
            bus3.req = 1'b0;
            chk("lat3 first ack", first, 4);
            chk("lat3 ack spacing", (second < 0) ? -1 : second - first, 5);
            chk("lat3 enable pulses", pulses, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
